// File: rtl/fat_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fat_sweep_ctrl
// Brief    : Force assign table controller: implication writes and backtrack sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module fat_sweep_ctrl #(
  parameter int VAR_NUM     = 8,
  parameter int VAR_NUM_LOG = 3,
  parameter int LVL_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imp_valid,
  output logic                   imp_ready,
  input  logic [VAR_NUM_LOG-1:0] imp_var,
  input  logic [LVL_W-1:0]       imp_lvl,
  input  logic                   bt_valid,
  output logic                   bt_ready,
  input  logic [LVL_W-1:0]       bt_lvl,
  output logic                   bt_done,
  output logic [VAR_NUM_LOG:0]   cleared_cnt,
  output logic                   busy,
  output logic                   fat_en,
  output logic                   fat_write,
  output logic [VAR_NUM_LOG-1:0] fat_address,
  output logic [LVL_W-1:0]       fat_in,
  input  logic [LVL_W-1:0]       fat_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [VAR_NUM_LOG-1:0] c_LAST_IDX = VAR_NUM_LOG'(VAR_NUM - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [VAR_NUM_LOG-1:0] r_idx;
  logic [LVL_W-1:0]       r_lvl_q;
  logic [VAR_NUM_LOG:0]   r_cleared_cnt;
  logic                   r_bt_done;
  logic                   w_clear;
  logic                   w_last;

  assign w_clear     = (r_state == ST_SWEEP) && (fat_out > r_lvl_q);
  assign w_last      = (r_idx == c_LAST_IDX);
  assign busy        = (r_state != ST_IDLE);
  assign bt_done     = r_bt_done;
  assign cleared_cnt = r_cleared_cnt;

  always_comb begin
    w_state_nxt = r_state;
    imp_ready   = 1'b0;
    bt_ready    = 1'b0;
    fat_en      = 1'b0;
    fat_write   = 1'b0;
    fat_address = '0;
    fat_in      = '0;
    case (r_state)
      ST_IDLE: begin
        bt_ready  = 1'b1;
        imp_ready = !bt_valid;
        if (bt_valid) begin
          w_state_nxt = ST_SWEEP;
        end else if (imp_valid) begin
          fat_en      = 1'b1;
          fat_write   = 1'b1;
          fat_address = imp_var;
          fat_in      = imp_lvl;
        end
      end
      ST_SWEEP: begin
        // Read-compare-clear in one cycle; write data stays zero.
        fat_en      = 1'b1;
        fat_address = r_idx;
        fat_write   = w_clear;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_lvl_q       <= '0;
      r_cleared_cnt <= '0;
      r_bt_done     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bt_done <= (r_state == ST_SWEEP) && w_last;
      case (r_state)
        ST_IDLE: begin
          if (bt_valid) begin
            r_lvl_q       <= bt_lvl;
            r_idx         <= '0;
            r_cleared_cnt <= '0;
          end
        end
        ST_SWEEP: begin
          if (w_clear) r_cleared_cnt <= r_cleared_cnt + (VAR_NUM_LOG+1)'(1);
          if (!w_last) r_idx <= r_idx + VAR_NUM_LOG'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fat_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fat_sweep_ctrl
// Brief    : Directed self-checking bench for fat_sweep_ctrl with a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fat_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imp_valid;
  logic       imp_ready;
  logic [2:0] imp_var;
  logic [2:0] imp_lvl;
  logic       bt_valid;
  logic       bt_ready;
  logic [2:0] bt_lvl;
  logic       bt_done;
  logic [3:0] cleared_cnt;
  logic       busy;
  logic       fat_en;
  logic       fat_write;
  logic [2:0] fat_address;
  logic [2:0] fat_in;
  logic [2:0] fat_out;

  logic [2:0] mem [8];
  logic       tb_init;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fat_sweep_ctrl #(.VAR_NUM(8), .VAR_NUM_LOG(3), .LVL_W(3)) dut (
    .clk(clk), .rst(rst),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_var(imp_var), .imp_lvl(imp_lvl),
    .bt_valid(bt_valid), .bt_ready(bt_ready), .bt_lvl(bt_lvl),
    .bt_done(bt_done), .cleared_cnt(cleared_cnt), .busy(busy),
    .fat_en(fat_en), .fat_write(fat_write), .fat_address(fat_address),
    .fat_in(fat_in), .fat_out(fat_out)
  );

  assign fat_out = mem[fat_address];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int k = 0; k < 8; k++) mem[k] <= 3'd0;
    end else if (fat_en && fat_write) begin
      mem[fat_address] <= fat_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic imp_write(input logic [2:0] v, input logic [2:0] l);
    imp_valid = 1'b1; imp_var = v; imp_lvl = l;
    #1;
    chk("imp_ready", imp_ready, 1);
    chk("imp_wr", {fat_en, fat_write}, 2'b11);
    chk("imp_addr", fat_address, v);
    chk("imp_data", fat_in, l);
    step();
    imp_valid = 1'b0;
  endtask

  // Cycles T+1..T+8: entry i processed in cycle T+1+i.
  task automatic sweep_check(input logic [7:0] exp_wr, input logic imp_held);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sw_busy", busy, 1);
      chk("sw_readies", {imp_ready, bt_ready}, 2'b00);
      chk("sw_en", fat_en, 1);
      chk("sw_addr", fat_address, i);
      chk("sw_write", fat_write, exp_wr[i]);
      if (exp_wr[i]) chk("sw_data", fat_in, 0);
      chk("sw_no_done", bt_done, 0);
      step();
    end
    #1;
    chk("done_pulse", bt_done, 1);
    chk("done_busy", busy, 1);
    chk("done_readies", {imp_ready, bt_ready}, 2'b00);
    chk("done_nowrite", fat_write, 0);
    if (!imp_held) begin
      step();
      #1;
      chk("idle_done_low", bt_done, 0);
      chk("idle_busy_low", busy, 0);
      chk("idle_bt_ready", bt_ready, 1);
    end
  endtask

  task automatic start_bt(input logic [2:0] l);
    bt_valid = 1'b1; bt_lvl = l;
    #1;
    chk("bt_ready", bt_ready, 1);
    chk("bt_cycle_nowrite", fat_write, 0);
    step();
    bt_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tb_init = 1'b1;
    imp_valid = 1'b0; imp_var = '0; imp_lvl = '0;
    bt_valid = 1'b0; bt_lvl = '0;
    step(); step();
    rst = 1'b0; tb_init = 1'b0;
    #1;
    chk("rst_bt_ready", bt_ready, 1);
    chk("rst_imp_ready", imp_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bt_done", bt_done, 0);
    chk("rst_cleared", cleared_cnt, 0);
    chk("rst_fat_bus", {fat_en, fat_write, fat_address, fat_in}, 8'h00);

    // Implications back to back; table becomes {3:2, 5:4, 6:3}
    imp_write(3'd3, 3'd2);
    imp_write(3'd5, 3'd4);
    imp_write(3'd6, 3'd3);
    #1;
    chk("idle_bus_quiet", {fat_en, fat_write, fat_address, fat_in}, 8'h00);
    chk("tbl_3", mem[3], 2);
    chk("tbl_5", mem[5], 4);

    // Backtrack to level 2: clears entries 5 and 6 only
    start_bt(3'd2);
    sweep_check(8'b0110_0000, 1'b0);
    chk("bt2_cleared", cleared_cnt, 2);
    chk("bt2_tbl_3", mem[3], 2);
    chk("bt2_tbl_5", mem[5], 0);
    chk("bt2_tbl_6", mem[6], 0);

    // Simultaneous requests: backtrack wins, implication held through the sweep
    imp_valid = 1'b1; imp_var = 3'd1; imp_lvl = 3'd5;
    bt_valid = 1'b1; bt_lvl = 3'd7;
    #1;
    chk("both_imp_ready", imp_ready, 0);
    chk("both_bt_ready", bt_ready, 1);
    chk("both_nowrite", fat_write, 0);
    step();
    bt_valid = 1'b0;
    sweep_check(8'b0000_0000, 1'b1);
    chk("bt7_cleared", cleared_cnt, 0);
    step();
    #1;
    chk("held_imp_ready", imp_ready, 1);
    chk("held_imp_wr", {fat_en, fat_write, fat_address, fat_in}, {2'b11, 3'd1, 3'd5});
    step();
    imp_valid = 1'b0;
    #1;
    chk("held_tbl_1", mem[1], 5);
    chk("cnt_holds", cleared_cnt, 0);

    // All entries nonzero, backtrack to level 0
    for (int v = 0; v < 8; v++) imp_write(3'(v), 3'((v % 7) + 1));
    start_bt(3'd0);
    sweep_check(8'b1111_1111, 1'b0);
    chk("bt0_cleared", cleared_cnt, 8);
    chk("bt0_tbl_7", mem[7], 0);
    chk("bt0_tbl_2", mem[2], 0);

    // Reset during sweep cycle T+4
    for (int v = 0; v < 8; v++) imp_write(3'(v), 3'd3);
    start_bt(3'd1);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_bt_done", bt_done, 0);
    chk("mrst_cleared", cleared_cnt, 0);
    chk("mrst_bt_ready", bt_ready, 1);
    chk("mrst_tbl_0", mem[0], 0);
    chk("mrst_tbl_2", mem[2], 0);
    for (int v = 4; v < 8; v++) chk("mrst_tbl_kept", mem[v], 3);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("mrst_no_done", {bt_done, busy}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fat_sweep_ctrl.md
# fat_sweep_ctrl

Controller for the BCP unit's force assign table. It arbitrates between single-cycle implication writes from the BCP datapath and backtrack requests from the decision logic. For each backtrack it runs a sequential sweep over every variable entry, clearing entries whose stored level exceeds the backtrack level. It is the only block that drives the table's enable, write, address and data inputs.

## Interface
- `VAR_NUM`, default 8: number of table entries, indexed 0..VAR_NUM-1.
- `VAR_NUM_LOG`, default 3: table address width.
- `LVL_W`, default 3: width of a stored entry (decision level; 0 = unassigned).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `imp_valid`  in  1  implication write request.
- `imp_ready`  out  1  implication accepted this cycle.
- `imp_var`  in  VAR_NUM_LOG  variable to write.
- `imp_lvl`  in  LVL_W  level to store.
- `bt_valid`  in  1  backtrack request.
- `bt_ready`  out  1  backtrack accepted this cycle.
- `bt_lvl`  in  LVL_W  target level; entries > bt_lvl are cleared.
- `bt_done`  out  1  one-cycle pulse when the sweep completes.
- `cleared_cnt`  out  VAR_NUM_LOG+1  entries cleared by the last sweep.
- `busy`  out  1  high in SWEEP and DONE.
- `fat_en`  out  1  table enable.
- `fat_write`  out  1  table write strobe.
- `fat_address`  out  VAR_NUM_LOG  table index.
- `fat_in`  out  LVL_W  table write data.
- `fat_out`  in  LVL_W  table read data, combinational from `fat_address`.

## Operation
- FSM states: IDLE, SWEEP, DONE. Registers: `state`, `idx` (VAR_NUM_LOG), `lvl_q` (LVL_W), `cleared_cnt`, `bt_done`.
- IDLE:
  - `bt_ready` = 1.
  - `imp_ready` = !bt_valid, so backtrack has priority when both requests arrive in the same cycle.
  - bt_valid: latch `lvl_q` = bt_lvl, set `idx` = 0, set `cleared_cnt` = 0, go to SWEEP. No table write this cycle.
  - Otherwise, if imp_valid: `fat_en` = 1, `fat_write` = 1, `fat_address` = imp_var, `fat_in` = imp_lvl. Stay in IDLE. Back-to-back implications are accepted every cycle.
  - imp_lvl = 0 is legal and clears the entry.
- SWEEP:
  - `fat_en` = 1, `fat_address` = idx.
  - If fat_out > lvl_q (unsigned): `fat_write` = 1, `fat_in` = 0, `cleared_cnt` += 1. Otherwise `fat_write` = 0.
  - idx += 1. When idx == VAR_NUM-1 this cycle, go to DONE instead. No wrap-around.
  - `imp_ready` = `bt_ready` = 0.
- DONE: `bt_done` = 1 and `busy` = 1 for exactly one cycle. Both readies are 0. Next state is IDLE.
- `cleared_cnt` holds its value from DONE until the next backtrack is accepted. Its maximum value, VAR_NUM, fits in VAR_NUM_LOG+1 bits.
- When no write occurs, `fat_en` = 0, `fat_write` = 0, `fat_address` = 0, `fat_in` = 0.
- Reset values: state IDLE, idx 0, lvl_q 0, cleared_cnt 0, bt_done 0, busy 0, fat_en 0, fat_write 0, fat_address 0, fat_in 0.
- Because IDLE is the reset state, `bt_ready` = 1 directly after reset and `imp_ready` = !bt_valid.
- Reset in mid-sweep abandons the sweep: no bt_done pulse, cleared_cnt returns to 0, and entries already cleared stay cleared. This block never resets the table contents.

## Timing
- Implication: a write accepted in cycle T is in the table at the T→T+1 edge. Latency is 1, throughput is 1 per cycle.
- Backtrack accepted in cycle T:
  - SWEEP occupies cycles T+1..T+VAR_NUM; entry i is processed in cycle T+1+i.
  - DONE and bt_done fall in cycle T+VAR_NUM+1.
  - IDLE resumes, with readies asserted, in cycle T+VAR_NUM+2.
- Each entry's compare uses `fat_out` from the same cycle (combinational read). The write lands at that cycle's edge.
- Requests held during busy cycles are not lost: the requester holds valid, and the request is accepted on return to IDLE.

## Test plan
- Reset, then write var 3 lvl 2 and var 5 lvl 4 on consecutive cycles → two write strobes (addr 3 / data 2, then addr 5 / data 4), imp_ready = 1 on both cycles.
- Table {3:2, 5:4, 6:3}, backtrack bt_lvl = 2 accepted at T → writes of 0 to addr 5 at T+6 and addr 6 at T+7 only, bt_done at T+9, cleared_cnt = 2, entry 3 still 2.
- bt_valid and imp_valid both high in IDLE → backtrack accepted, imp_ready = 0 for 10 cycles, then the implication is written in cycle T+10.
- All 8 entries nonzero, bt_lvl = 0 → 8 consecutive write strobes (addr 0..7, data 0), cleared_cnt = 8.
- rst asserted in sweep cycle T+4 → IDLE next cycle, no bt_done, cleared_cnt = 0, entries 4..7 unchanged.
- imp_valid held throughout a sweep with bt_lvl = 7 → no write strobes during SWEEP, cleared_cnt = 0, bt_done pulse, then the implication is written on return to IDLE.
